// File: rtl/rsa_crt_decrypt_if.sv
// Command/data bundle for the CRT RSA decryptor: key material, ciphertext,
// and the go/done/busy handshake shared with the tag-side encryptor.
interface rsa_crt_decrypt_if #(
  parameter int W = 16
);
  logic [2*W-1:0] cipher_text;
  logic [W-1:0]   p;
  logic [W-1:0]   q;
  logic [W-1:0]   dp;
  logic [W-1:0]   dq;
  logic [W-1:0]   qinv;
  logic           go;
  logic [2*W-1:0] plain_text;
  logic           done;
  logic           busy;

  modport master (
    output cipher_text, p, q, dp, dq, qinv, go,
    input  plain_text, done, busy
  );

  modport slave (
    input  cipher_text, p, q, dp, dq, qinv, go,
    output plain_text, done, busy
  );
endinterface

// File: rtl/rsa_crt_decrypt.sv
// CRT RSA decryptor: m = c^d mod pq via two half-width exponentiations and
// Garner recombination, fixed latency independent of the operand values.
module rsa_crt_decrypt #(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             reset,
  rsa_crt_decrypt_if.slave bus
);
  localparam int CW = $clog2(2 * W);
  localparam int EW = $clog2(W);
  localparam logic [CW-1:0] RED_LAST = CW'(2 * W - 1);
  localparam logic [CW-1:0] MM_LAST  = CW'(W - 1);
  localparam logic [EW-1:0] E_LAST   = EW'(W - 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_RED_P = 4'd1;
  localparam logic [3:0] S_EXP_P = 4'd2;
  localparam logic [3:0] S_RED_Q = 4'd3;
  localparam logic [3:0] S_EXP_Q = 4'd4;
  localparam logic [3:0] S_SUB   = 4'd5;
  localparam logic [3:0] S_HMUL  = 4'd6;
  localparam logic [3:0] S_MMUL  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  logic [3:0]     state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [EW-1:0]  e_cnt_reg;
  logic           phase_reg;

  logic [2*W-1:0] c_reg;
  logic [W-1:0]   p_reg;
  logic [W-1:0]   q_reg;
  logic [W-1:0]   dp_reg;
  logic [W-1:0]   dq_reg;
  logic [W-1:0]   qinv_reg;

  logic [2*W-1:0] c_sh_reg;
  logic [W-1:0]   rem_reg;
  logic [W-1:0]   cp_reg;
  logic [W-1:0]   x_reg;
  logic [W-1:0]   e_sh_reg;
  logic [W-1:0]   m1_reg;
  logic [W-1:0]   m2_reg;

  logic [W-1:0]   mm_a_reg;
  logic [W-1:0]   mm_b_reg;
  logic [W-1:0]   mm_acc_reg;

  logic [2*W-1:0] mul_acc_reg;
  logic [2*W-1:0] mul_a_reg;
  logic [W-1:0]   mul_b_reg;

  logic [2*W-1:0] plain_reg;
  logic           done_reg;
  logic           busy_reg;

  logic           use_q;
  logic [W-1:0]   mod_n;
  logic [W:0]     red_shift;
  logic [W-1:0]   red_res;
  logic [W+1:0]   mm_n;
  logic [W+1:0]   mm_dbl;
  logic [W+1:0]   mm_half;
  logic [W+1:0]   mm_sum;
  logic [W-1:0]   mm_step;
  logic [W-1:0]   x_after_mul;
  logic [W-1:0]   m2_red;
  logic [W-1:0]   sub_t;
  logic [2*W-1:0] mul_next;

  assign bus.plain_text = plain_reg;
  assign bus.done       = done_reg;
  assign bus.busy       = busy_reg;

  always_comb begin
    use_q     = (state_reg == S_RED_Q) || (state_reg == S_EXP_Q);
    mod_n     = use_q ? q_reg : p_reg;

    // Restoring division step: bring in the next ciphertext bit, subtract once.
    red_shift = {rem_reg, c_sh_reg[2*W-1]};
    red_res   = (red_shift >= {1'b0, mod_n}) ? W'(red_shift - {1'b0, mod_n})
                                             : red_shift[W-1:0];

    // Interleaved modmul step: double, reduce, conditionally add a, reduce.
    mm_n      = {2'b00, mod_n};
    mm_dbl    = {1'b0, mm_acc_reg, 1'b0};
    mm_half   = (mm_dbl >= mm_n) ? mm_dbl - mm_n : mm_dbl;
    mm_sum    = mm_half + (mm_b_reg[W-1] ? {2'b00, mm_a_reg} : {(W+2){1'b0}});
    mm_step   = (mm_sum >= mm_n) ? W'(mm_sum - mm_n) : mm_sum[W-1:0];

    x_after_mul = e_sh_reg[W-1] ? mm_step : x_reg;

    // m2 < q can exceed p; one subtract suffices while q < 2p.
    m2_red    = (m2_reg >= p_reg) ? m2_reg - p_reg : m2_reg;
    sub_t     = (m1_reg >= m2_red) ? m1_reg - m2_red : m1_reg + p_reg - m2_red;

    mul_next  = mul_acc_reg + (mul_b_reg[0] ? mul_a_reg : {(2*W){1'b0}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      e_cnt_reg   <= '0;
      phase_reg   <= 1'b0;
      c_reg       <= '0;
      p_reg       <= '0;
      q_reg       <= '0;
      dp_reg      <= '0;
      dq_reg      <= '0;
      qinv_reg    <= '0;
      c_sh_reg    <= '0;
      rem_reg     <= '0;
      cp_reg      <= '0;
      x_reg       <= '0;
      e_sh_reg    <= '0;
      m1_reg      <= '0;
      m2_reg      <= '0;
      mm_a_reg    <= '0;
      mm_b_reg    <= '0;
      mm_acc_reg  <= '0;
      mul_acc_reg <= '0;
      mul_a_reg   <= '0;
      mul_b_reg   <= '0;
      plain_reg   <= '0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.go) begin
            c_reg     <= bus.cipher_text;
            p_reg     <= bus.p;
            q_reg     <= bus.q;
            dp_reg    <= bus.dp;
            dq_reg    <= bus.dq;
            qinv_reg  <= bus.qinv;
            c_sh_reg  <= bus.cipher_text;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= S_RED_P;
          end
        end

        S_RED_P, S_RED_Q: begin
          c_sh_reg <= c_sh_reg << 1;
          rem_reg  <= red_res;
          cnt_reg  <= cnt_reg + CW'(1);
          if (cnt_reg == RED_LAST) begin
            // First square of the exponentiation is 1*1 with accumulator 1.
            cp_reg     <= red_res;
            x_reg      <= W'(1);
            mm_a_reg   <= W'(1);
            mm_b_reg   <= W'(1);
            mm_acc_reg <= '0;
            cnt_reg    <= '0;
            e_cnt_reg  <= '0;
            phase_reg  <= 1'b0;
            if (state_reg == S_RED_P) begin
              e_sh_reg  <= dp_reg;
              state_reg <= S_EXP_P;
            end else begin
              e_sh_reg  <= dq_reg;
              state_reg <= S_EXP_Q;
            end
          end
        end

        S_EXP_P, S_EXP_Q: begin
          mm_acc_reg <= mm_step;
          mm_b_reg   <= mm_b_reg << 1;
          cnt_reg    <= cnt_reg + CW'(1);
          if (cnt_reg == MM_LAST) begin
            cnt_reg    <= '0;
            mm_acc_reg <= '0;
            if (!phase_reg) begin
              // Square finished; multiply it by cp regardless of the exponent bit.
              x_reg     <= mm_step;
              mm_a_reg  <= cp_reg;
              mm_b_reg  <= mm_step;
              phase_reg <= 1'b1;
            end else begin
              x_reg     <= x_after_mul;
              mm_a_reg  <= x_after_mul;
              mm_b_reg  <= x_after_mul;
              phase_reg <= 1'b0;
              e_sh_reg  <= e_sh_reg << 1;
              e_cnt_reg <= e_cnt_reg + EW'(1);
              if (e_cnt_reg == E_LAST) begin
                if (state_reg == S_EXP_P) begin
                  m1_reg    <= x_after_mul;
                  rem_reg   <= '0;
                  c_sh_reg  <= c_reg;
                  state_reg <= S_RED_Q;
                end else begin
                  m2_reg    <= x_after_mul;
                  state_reg <= S_SUB;
                end
              end
            end
          end
        end

        S_SUB: begin
          mm_a_reg   <= qinv_reg;
          mm_b_reg   <= sub_t;
          mm_acc_reg <= '0;
          cnt_reg    <= '0;
          state_reg  <= S_HMUL;
        end

        S_HMUL: begin
          mm_acc_reg <= mm_step;
          mm_b_reg   <= mm_b_reg << 1;
          cnt_reg    <= cnt_reg + CW'(1);
          if (cnt_reg == MM_LAST) begin
            mul_acc_reg <= {{W{1'b0}}, m2_reg};
            mul_a_reg   <= {{W{1'b0}}, q_reg};
            mul_b_reg   <= mm_step;
            cnt_reg     <= '0;
            state_reg   <= S_MMUL;
          end
        end

        S_MMUL: begin
          // LSB-first shift-add so m2 can seed the accumulator directly.
          mul_acc_reg <= mul_next;
          mul_a_reg   <= mul_a_reg << 1;
          mul_b_reg   <= mul_b_reg >> 1;
          cnt_reg     <= cnt_reg + CW'(1);
          if (cnt_reg == MM_LAST) begin
            plain_reg <= mul_next;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= S_DONE;
          end
        end

        S_DONE: begin
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_crt_decrypt.sv
// Directed and randomized bench for rsa_crt_decrypt; random keys are checked
// by an RSA encrypt/decrypt round trip computed with plain integer arithmetic.
module tb_rsa_crt_decrypt;
  localparam int W = 16;
  localparam int LATENCY = 4 * W * W + 6 * W + 1;
  localparam int PERIOD  = LATENCY + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   go_hold = 1'b0;

  int   edges;
  bit   got;
  bit   busy_ok;

  longint unsigned rp, rq, rn, rphi, rd, rm, rc;
  logic [15:0]     rdp, rdq, rqinv;

  rsa_crt_decrypt_if #(.W(W)) bus ();

  rsa_crt_decrypt #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned modexp(input longint unsigned b,
                                              input longint unsigned e,
                                              input longint unsigned m);
    longint unsigned r = 1 % m;
    longint unsigned x = b % m;
    longint unsigned k = e;
    while (k != 0) begin
      if (k[0]) r = (r * x) % m;
      x = (x * x) % m;
      k = k >> 1;
    end
    return r;
  endfunction

  function automatic longint modinv(input longint a, input longint m);
    longint t = 0, nt = 1, r = m, nr = a % m, qq, tmp;
    while (nr != 0) begin
      qq  = r / nr;
      tmp = t - qq * nt; t = nt; nt = tmp;
      tmp = r - qq * nr; r = nr; nr = tmp;
    end
    if (t < 0) t = t + m;
    return t;
  endfunction

  function automatic bit is_prime(input int unsigned x);
    if (x < 2) return 1'b0;
    if (x % 2 == 0) return (x == 2);
    for (int unsigned i = 3; i * i <= x; i += 2)
      if (x % i == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int unsigned rand_prime();
    int unsigned x = $urandom_range(65000, 32771) | 1;
    while (!is_prime(x)) x += 2;
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [31:0] c, input logic [15:0] p, input logic [15:0] q,
                           input logic [15:0] dp, input logic [15:0] dq, input logic [15:0] qinv);
    repeat (2) begin @(posedge clk); #1; end
    bus.cipher_text = c;
    bus.p = p; bus.q = q; bus.dp = dp; bus.dq = dq; bus.qinv = qinv;
    bus.go = 1'b1;
    @(posedge clk); #1;
  endtask

  // kind 1: re-pulse go with a new ciphertext; kind 2: one-cycle reset.
  task automatic run_wait(input int max, input int act_at, input int kind,
                          output int n, output bit hit, output bit bz);
    n = 0; hit = 1'b0; bz = 1'b1;
    while (n < max && !hit) begin
      if (n == act_at && kind == 1) begin
        bus.go = 1'b1;
        bus.cipher_text = 32'd23;
      end else if (n == act_at && kind == 2) begin
        reset = 1'b1;
      end else begin
        if (!go_hold) bus.go = 1'b0;
        reset = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (bus.done) hit = 1'b1;
      else if (!bus.busy) bz = 1'b0;
    end
    bus.go = go_hold;
    reset = 1'b0;
  endtask

  initial begin
    bus.cipher_text = '0;
    bus.p = '0; bus.q = '0; bus.dp = '0; bus.dq = '0; bus.qinv = '0;
    bus.go = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_plain", bus.plain_text, 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;

    // Small-key vector with latency and busy coverage.
    start_run(32'd4, 16'd11, 16'd3, 16'd7, 16'd1, 16'd4);
    check("small_busy_start", 32'(bus.busy), 32'd1);
    run_wait(LATENCY + 50, -1, 0, edges, got, busy_ok);
    $display("run small: c=4 plain_text=%0d latency=%0d", bus.plain_text, edges);
    check("small_latency", edges, LATENCY);
    check("small_plain", bus.plain_text, 32'd16);
    check("small_busy_throughout", 32'(busy_ok), 32'd1);
    check("small_busy_at_done", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("small_done_pulse_width", 32'(bus.done), 32'd0);
    check("small_plain_held", bus.plain_text, 32'd16);

    // Borrow path and trivial ciphertexts.
    start_run(32'd23, 16'd11, 16'd3, 16'd7, 16'd1, 16'd4);
    run_wait(LATENCY + 50, -1, 0, edges, got, busy_ok);
    $display("run borrow: c=23 plain_text=%0d latency=%0d", bus.plain_text, edges);
    check("borrow_plain", bus.plain_text, 32'd23);
    start_run(32'd0, 16'd11, 16'd3, 16'd7, 16'd1, 16'd4);
    run_wait(LATENCY + 50, -1, 0, edges, got, busy_ok);
    $display("run zero: c=0 plain_text=%0d latency=%0d", bus.plain_text, edges);
    check("zero_plain", bus.plain_text, 32'd0);
    start_run(32'd1, 16'd11, 16'd3, 16'd7, 16'd1, 16'd4);
    run_wait(LATENCY + 50, -1, 0, edges, got, busy_ok);
    $display("run one: c=1 plain_text=%0d latency=%0d", bus.plain_text, edges);
    check("one_plain", bus.plain_text, 32'd1);

    // Production keys, then a round trip through the encryptor model.
    start_run(32'd36348, 16'd223, 16'd163, 16'd137, 16'd71, 16'd26);
    run_wait(LATENCY + 50, -1, 0, edges, got, busy_ok);
    $display("run prod: c=36348 plain_text=%0d latency=%0d", bus.plain_text, edges);
    check("prod_plain", bus.plain_text, 32'd36348);
    rc = modexp(64'd5, 64'd65537, 64'd36349);
    start_run(32'(rc), 16'd223, 16'd163, 16'd137, 16'd71, 16'd26);
    run_wait(LATENCY + 50, -1, 0, edges, got, busy_ok);
    $display("run roundtrip: c=%0d plain_text=%0d latency=%0d", rc, bus.plain_text, edges);
    check("roundtrip_plain", bus.plain_text, 32'd5);

    // go re-pulsed mid-run with a different ciphertext must be ignored.
    start_run(32'd4, 16'd11, 16'd3, 16'd7, 16'd1, 16'd4);
    run_wait(LATENCY + 50, 300, 1, edges, got, busy_ok);
    $display("run repulse: c=4 plain_text=%0d latency=%0d", bus.plain_text, edges);
    check("repulse_latency", edges, LATENCY);
    check("repulse_plain", bus.plain_text, 32'd16);
    run_wait(LATENCY + 100, -1, 0, edges, got, busy_ok);
    $display("run repulse_idle: extra_done=%0d", got);
    check("repulse_no_second_done", 32'(got), 32'd0);

    // go held high: back-to-back runs at a fixed period.
    go_hold = 1'b1;
    start_run(32'd23, 16'd11, 16'd3, 16'd7, 16'd1, 16'd4);
    run_wait(LATENCY + 50, -1, 0, edges, got, busy_ok);
    $display("run held0: c=23 plain_text=%0d latency=%0d", bus.plain_text, edges);
    check("held_first_latency", edges, LATENCY);
    for (int k = 0; k < 3; k++) begin
      run_wait(PERIOD + 50, -1, 0, edges, got, busy_ok);
      $display("run held%0d: c=23 plain_text=%0d period=%0d", k + 1, bus.plain_text, edges);
      check("held_period", edges, PERIOD);
      check("held_plain", bus.plain_text, 32'd23);
    end
    go_hold = 1'b0;
    bus.go = 1'b0;

    // Reset at cycle 600 aborts the run without a done pulse.
    start_run(32'd1, 16'd11, 16'd3, 16'd7, 16'd1, 16'd4);
    run_wait(LATENCY + 200, 599, 2, edges, got, busy_ok);
    $display("run aborted: done_seen=%0d busy=%0d plain_text=%0d", got, bus.busy, bus.plain_text);
    check("abort_no_done", 32'(got), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_plain", bus.plain_text, 32'd0);
    start_run(32'd4, 16'd11, 16'd3, 16'd7, 16'd1, 16'd4);
    run_wait(LATENCY + 50, -1, 0, edges, got, busy_ok);
    $display("run after_reset: c=4 plain_text=%0d latency=%0d", bus.plain_text, edges);
    check("after_reset_latency", edges, LATENCY);
    check("after_reset_plain", bus.plain_text, 32'd16);

    // Random 16-bit prime keys; expected plaintext is the message encrypted.
    for (int k = 0; k < 6; k++) begin
      rp = rand_prime();
      rq = rand_prime();
      while (rq == rp) rq = rand_prime();
      rn    = rp * rq;
      rphi  = (rp - 1) * (rq - 1);
      rd    = 64'(modinv(longint'(65537), longint'(rphi)));
      rdp   = 16'(rd % (rp - 1));
      rdq   = 16'(rd % (rq - 1));
      rqinv = 16'(modinv(longint'(rq % rp), longint'(rp)));
      rm    = 64'($urandom_range(32'(rn - 1), 0));
      rc    = modexp(rm, 64'd65537, rn);
      start_run(32'(rc), 16'(rp), 16'(rq), rdp, rdq, rqinv);
      run_wait(LATENCY + 50, -1, 0, edges, got, busy_ok);
      $display("run random%0d: p=%0d q=%0d c=%0d plain_text=%0d expected=%0d latency=%0d",
               k, rp, rq, rc, bus.plain_text, rm, edges);
      check("random_latency", edges, LATENCY);
      check("random_plain", bus.plain_text, 32'(rm));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rsa_crt_decrypt.md
Name: rsa_crt_decrypt

Overview:
- Reader-side RSA decryptor; the counterpart of the tag-side rsa_rfid encryptor (c = m^e mod n).
- Recovers plaintext m = c^d mod n, with n = p*q, using the Chinese Remainder Theorem: two half-width modular exponentiations followed by Garner recombination.
- Uses the same go/done command handshake as the encryptor, so the encryptor's output_text connects directly to cipher_text.
- Latency is fixed and independent of the data.

Parameters:
- W, 16, prime width in bits. Ciphertext and plaintext are 2W bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- cipher_text  input  2W  ciphertext c; must satisfy c < p*q
- p  input  W  odd prime
- q  input  W  odd prime, q != p
- dp  input  W  d mod (p-1)
- dq  input  W  d mod (q-1)
- qinv  input  W  q^-1 mod p
- go  input  1  start request; sampled only in IDLE
- plain_text  output  2W  recovered m; held until the next accepted go
- done  output  1  one-cycle pulse when plain_text becomes valid
- busy  output  1  high from the cycle after go is accepted until done

Behaviour:
- Reset: state=IDLE, plain_text=0, done=0, busy=0, all internal registers=0. Reset overrides everything, including a run in progress; no done pulse follows an aborted run.
- IDLE, go=1:
  - Latch all inputs into internal registers.
  - Input changes after the accepting edge are ignored.
  - Go to RED_P.
- go while busy: ignored. Not queued.
- RED_P (2W cycles): cp = c mod p by restoring shift-subtract, one quotient bit per cycle, MSB first.
- EXP_P (2W^2 cycles): m1 = cp^dp mod p.
  - Left-to-right binary exponentiation over all W bits of dp, MSB first. Leading zeros are not skipped.
  - Per bit: square (modmul), then multiply by cp (modmul). The multiply result is kept only if the exponent bit is 1; it is discarded otherwise, which keeps latency constant.
  - Accumulator starts at 1, so dp=0 gives m1=1.
- modmul (W cycles): interleaved shift-add.
  - Per cycle: acc = 2*acc mod N, then acc = acc + a mod N if b[i]=1.
  - Each reduction is a single conditional subtract.
  - Internal width is W+2 to avoid overflow.
- RED_Q then EXP_Q: identical procedure with q and dq, giving m2.
- SUB (1 cycle): t = m1 - m2 mod p.
  - If m1 >= m2: t = m1 - m2.
  - Else: t = m1 + p - m2.
  - m2 < q may exceed p. Reduce m2 mod p by conditional subtract before the subtract.
- HMUL (W cycles): h = qinv * t mod p, using modmul.
- MMUL (W cycles): m = m2 + h*q, plain 2W-bit shift-add multiply-accumulate, no reduction. The result is < p*q by construction.
- DONE (1 cycle):
  - plain_text <= m, done=1, busy=0. plain_text updates on the edge entering DONE.
  - Next state IDLE. A go seen in the DONE cycle is ignored; go is accepted only from IDLE.
- Latency: the edge that samples go enters RED_P. DONE is entered exactly 4W^2+6W+1 edges later (1121 for W=16). The next go is accepted at the edge after the DONE cycle.
- Preconditions are not checked by hardware: c < p*q, qinv*q ≡ 1 (mod p). Output is undefined if they are violated.

Test Plan:
- Small-key vector:
  - Stimulus: W=16, p=11, q=3, dp=7, dq=1, qinv=4, c=4, go pulse.
  - Required: done exactly 1121 edges after the go-sampling edge; plain_text=16; busy high throughout.
- Borrow path (m1=1 < m2=2):
  - Stimulus: same keys, c=23.
  - Required: plain_text=23.
  - Then c=0 -> plain_text=0; c=1 -> plain_text=1.
- Production keys:
  - Stimulus: p=223, q=163, dp=137, dq=71, qinv=26, c=36348.
  - Required: plain_text=36348 (d is odd).
- Round trip with the encryptor:
  - Stimulus: rsa_rfid(input_text=5, key=65537, mod=36349); its output_text drives cipher_text with the production keys.
  - Required: plain_text=5.
- Handshake:
  - Stimulus: go re-pulsed while busy, with cipher_text changed mid-run.
  - Required: ignored; exactly one done and the original result.
  - Stimulus: go held high continuously.
  - Required: new run accepted one cycle after each done; done pulses every 1123 cycles.
- Reset mid-run:
  - Stimulus: reset asserted for 1 cycle at cycle 600.
  - Required: busy=0, plain_text=0, done never pulses for that run.
  - Then a fresh go with c=4 (small keys) -> plain_text=16.
